task_scheduler_param: RTL and testbench

TASK_SCHEDULER_PARAM -- requirements
Module: task_scheduler_param

---
 rtl/task_scheduler_param.sv | 226 ++++++++++++++++++++++
 tb/tb_task_scheduler_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/task_scheduler_param.sv
// SLOTS-entry task table serviced one task per cycle under a policy latched at start:
// first-come-first-served, shortest-remaining-first (preemptive) or round-robin.
module task_scheduler_param #(
  parameter int SLOTS   = 5,
  parameter int RT_W    = 4,
  parameter int ID_W    = 16,
  parameter int QUANTUM = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st,
  input  logic [1:0]                 mode,
  input  logic                       inputtask,
  input  logic [RT_W+ID_W-1:0]       task_in,
  output logic [ID_W-1:0]            task_out,
  output logic                       task_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       drop,
  output logic [$clog2(SLOTS+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(SLOTS);
  localparam int OCC_W = $clog2(SLOTS + 1);
  localparam logic [7:0] QUANT = 8'(QUANTUM);
  localparam logic [1:0] MODE_SJF = 2'd1;
  localparam logic [1:0] MODE_RR  = 2'd2;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [RT_W-1:0]  rt_q   [SLOTS];
  logic [RT_W-1:0]  rt_d   [SLOTS];
  logic [ID_W-1:0]  id_q   [SLOTS];
  logic [ID_W-1:0]  id_d   [SLOTS];
  logic [IDX_W-1:0] rank_q [SLOTS];
  logic [IDX_W-1:0] rank_d [SLOTS];
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       quant_q, quant_d;
  logic             drop_q, drop_d;

  logic [SLOTS-1:0] occ_s;
  logic [OCC_W-1:0] occ_cnt_s;
  logic             exec_s, full_s;
  logic [RT_W-1:0]  in_rt_s;
  logic [ID_W-1:0]  in_id_s;

  logic             fc_hit_s, sj_hit_s, rr_hit_s, rr_keep_s, sel_vld_s;
  logic [IDX_W-1:0] fc_idx_s, sj_idx_s, rr_idx_s, sel_s;
  logic [IDX_W-1:0] fc_rank_s, sj_rank_s;
  logic [RT_W-1:0]  sj_rt_s;
  int               rr_start_s;

  logic             free_s, ins_ok_s, slot_hit_s;
  logic [IDX_W-1:0] slot_idx_s;

  assign exec_s  = (state_q == EXEC);
  assign in_rt_s = task_in[RT_W+ID_W-1:ID_W];
  assign in_id_s = task_in[ID_W-1:0];
  assign full_s  = &occ_s;

  // Occupancy view of the registered slot table
  always_comb begin
    occ_cnt_s = '0;
    for (int i = 0; i < SLOTS; i++) begin
      occ_s[i]  = (rt_q[i] != '0);
      occ_cnt_s = occ_cnt_s + OCC_W'(occ_s[i]);
    end
  end

  // Candidate per policy, then the one serviced this cycle
  always_comb begin
    fc_hit_s  = 1'b0;
    fc_idx_s  = '0;
    fc_rank_s = '0;
    sj_hit_s  = 1'b0;
    sj_idx_s  = '0;
    sj_rank_s = '0;
    sj_rt_s   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (occ_s[i] && (!fc_hit_s || (rank_q[i] < fc_rank_s))) begin
        fc_hit_s  = 1'b1;
        fc_idx_s  = IDX_W'(i);
        fc_rank_s = rank_q[i];
      end else begin
        fc_hit_s  = fc_hit_s;
      end
      if (occ_s[i] && (!sj_hit_s || (rt_q[i] < sj_rt_s) ||
                       ((rt_q[i] == sj_rt_s) && (rank_q[i] < sj_rank_s)))) begin
        sj_hit_s  = 1'b1;
        sj_idx_s  = IDX_W'(i);
        sj_rank_s = rank_q[i];
        sj_rt_s   = rt_q[i];
      end else begin
        sj_hit_s  = sj_hit_s;
      end
    end

    // An expired slot searches from the next index so it is reconsidered last
    rr_keep_s  = occ_s[rr_ptr_q] && (quant_q < QUANT);
    rr_start_s = occ_s[rr_ptr_q] ? int'(rr_ptr_q) + 1 : int'(rr_ptr_q);
    rr_hit_s   = 1'b0;
    rr_idx_s   = rr_ptr_q;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (occ_s[IDX_W'((rr_start_s + i) % SLOTS)]) begin
        rr_hit_s = 1'b1;
        rr_idx_s = IDX_W'((rr_start_s + i) % SLOTS);
      end else begin
        rr_hit_s = rr_hit_s;
      end
    end

    case (mode_q)
      MODE_SJF: begin
        sel_vld_s = exec_s && sj_hit_s;
        sel_s     = sj_idx_s;
      end
      MODE_RR: begin
        sel_vld_s = exec_s && rr_hit_s;
        sel_s     = rr_keep_s ? rr_ptr_q : rr_idx_s;
      end
      default: begin
        sel_vld_s = exec_s && fc_hit_s;
        sel_s     = fc_idx_s;
      end
    endcase
  end

  // Service, free, insert and round-robin bookkeeping for the next edge
  always_comb begin
    rt_d     = rt_q;
    id_d     = id_q;
    rank_d   = rank_q;
    rr_ptr_d = rr_ptr_q;
    quant_d  = 8'd0;

    slot_hit_s = 1'b0;
    slot_idx_s = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ_s[i]) begin
        slot_hit_s = 1'b1;
        slot_idx_s = IDX_W'(i);
      end else begin
        slot_hit_s = slot_hit_s;
      end
    end

    free_s   = sel_vld_s && (rt_q[sel_s] == RT_W'(1));
    ins_ok_s = exec_s && inputtask && (in_rt_s != '0) && !full_s && slot_hit_s;
    drop_d   = exec_s && inputtask && (in_rt_s != '0) && full_s;

    if (sel_vld_s) begin
      rt_d[sel_s] = rt_q[sel_s] - RT_W'(1);
    end else begin
      rt_d[sel_s] = rt_q[sel_s];
    end

    // Closing the gap keeps ranks dense so a new arrival always ranks last
    if (free_s) begin
      for (int i = 0; i < SLOTS; i++) begin
        rank_d[i] = (occ_s[i] && (rank_q[i] > rank_q[sel_s])) ? rank_q[i] - IDX_W'(1) : rank_q[i];
      end
      rank_d[sel_s] = '0;
    end else begin
      rank_d = rank_q;
    end

    if (ins_ok_s) begin
      rt_d[slot_idx_s]   = in_rt_s;
      id_d[slot_idx_s]   = in_id_s;
      rank_d[slot_idx_s] = IDX_W'(occ_cnt_s - OCC_W'(free_s));
    end else begin
      id_d = id_q;
    end

    if (sel_vld_s && (mode_q == MODE_RR)) begin
      rr_ptr_d = sel_s;
      quant_d  = rr_keep_s ? quant_q + 8'd1 : 8'd1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Controller FSM and slot table registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= 2'd0;
      rr_ptr_q <= '0;
      quant_q  <= 8'd0;
      drop_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        rt_q[i]   <= '0;
        id_q[i]   <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (st) begin
            state_q <= EXEC;
            mode_q  <= mode;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC:    state_q <= EXEC;
        default: state_q <= IDLE;
      endcase
      rt_q     <= rt_d;
      id_q     <= id_d;
      rank_q   <= rank_d;
      rr_ptr_q <= rr_ptr_d;
      quant_q  <= quant_d;
      drop_q   <= drop_d;
    end
  end

  assign task_out   = sel_vld_s ? id_q[sel_s] : '1;
  assign task_valid = sel_vld_s;
  assign empty      = ~|occ_s;
  assign full       = full_s;
  assign drop       = drop_q;
  assign occupancy  = occ_cnt_s;

endmodule

// File: tb/tb_task_scheduler_param.sv
// Directed bench for task_scheduler_param with default parameters.
module tb_task_scheduler_param;
  logic        clk = 1'b0;
  logic        rst, st, inputtask;
  logic [1:0]  mode;
  logic [19:0] task_in;
  logic [15:0] task_out;
  logic        task_valid, empty, full, drop;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rr_exp [6] = '{16'h00A1, 16'h00A1, 16'h00B2, 16'h00B2, 16'h00A1, 16'h00B2};

  always #5 clk = ~clk;

  task_scheduler_param dut (
    .clk(clk), .rst(rst), .st(st), .mode(mode), .inputtask(inputtask),
    .task_in(task_in), .task_out(task_out), .task_valid(task_valid),
    .empty(empty), .full(full), .drop(drop), .occupancy(occupancy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] rt, input logic [15:0] id);
    inputtask = 1'b1;
    task_in   = {rt, id};
  endtask

  task automatic no_put();
    inputtask = 1'b0;
    task_in   = 20'h0;
  endtask

  task automatic expect_svc(input string tag, input logic [15:0] id);
    check_eq({tag, ".out"}, 32'(task_out), 32'(id));
    check_eq({tag, ".vld"}, 32'(task_valid), 32'(id != 16'hFFFF));
  endtask

  task automatic do_reset();
    rst = 1'b0; st = 1'b0; mode = 2'd0; no_put();
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic start(input logic [1:0] m);
    mode = m; st = 1'b1;
    step();
    st = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st = 1'b0; mode = 2'd0; no_put();
    step();
    expect_svc("rst.during", 16'hFFFF);
    check_eq("rst.empty", 32'(empty), 32'd1);
    check_eq("rst.full", 32'(full), 32'd0);
    check_eq("rst.occ", 32'(occupancy), 32'd0);
    check_eq("rst.drop", 32'(drop), 32'd0);

    // IDLE ignores inserts
    do_reset();
    put(4'd3, 16'h0099); step(); step();
    expect_svc("idle.out", 16'hFFFF);
    check_eq("idle.occ", 32'(occupancy), 32'd0);
    no_put();

    // FCFS
    do_reset(); start(2'd0);
    put(4'd2, 16'h00A1); step();
    expect_svc("fcfs.c1", 16'h00A1); put(4'd1, 16'h00B2); step();
    expect_svc("fcfs.c2", 16'h00A1);
    check_eq("fcfs.occ2", 32'(occupancy), 32'd2); no_put(); step();
    expect_svc("fcfs.c3", 16'h00B2); step();
    expect_svc("fcfs.c4", 16'hFFFF);
    check_eq("fcfs.empty", 32'(empty), 32'd1);

    // SJF, preemptive
    do_reset(); start(2'd1);
    put(4'd3, 16'h00A1); step();
    expect_svc("sjf.c1", 16'h00A1); put(4'd1, 16'h00B2); step();
    expect_svc("sjf.c2", 16'h00B2); put(4'd1, 16'h00C3); step();
    expect_svc("sjf.c3", 16'h00C3); no_put(); step();
    expect_svc("sjf.c4", 16'h00A1); step();
    expect_svc("sjf.c5", 16'h00A1); step();
    expect_svc("sjf.c6", 16'hFFFF);
    check_eq("sjf.empty", 32'(empty), 32'd1);

    // Reserved mode acts as FCFS; mode changes after start are ignored
    do_reset(); start(2'd3); mode = 2'd1;
    put(4'd3, 16'h00C1); step();
    expect_svc("latch.c1", 16'h00C1); put(4'd1, 16'h00C2); step();
    expect_svc("latch.c2", 16'h00C1); no_put(); step();
    expect_svc("latch.c3", 16'h00C1); step();
    expect_svc("latch.c4", 16'h00C2); step();
    expect_svc("latch.c5", 16'hFFFF);

    // Round-robin, QUANTUM=2
    do_reset(); start(2'd2);
    put(4'd3, 16'h00A1); step();
    put(4'd3, 16'h00B2);
    for (int k = 0; k < 6; k++) begin
      expect_svc($sformatf("rr.c%0d", k + 1), rr_exp[k]);
      step();
      no_put();
    end
    expect_svc("rr.end", 16'hFFFF);
    check_eq("rr.empty", 32'(empty), 32'd1);

    // Full, drop and reuse of a slot freed in the rejecting cycle
    do_reset(); start(2'd0);
    put(4'd5, 16'h0010); step();
    expect_svc("full.c1", 16'h0010);
    for (int k = 1; k < 5; k++) begin
      put(4'd9, 16'h0010 + 16'(k)); step();
    end
    check_eq("full.full", 32'(full), 32'd1);
    check_eq("full.occ5", 32'(occupancy), 32'd5);
    check_eq("full.drop0", 32'(drop), 32'd0);
    expect_svc("full.c5", 16'h0010);
    put(4'd9, 16'h0015); step();
    check_eq("full.drop1", 32'(drop), 32'd1);
    check_eq("full.notfull", 32'(full), 32'd0);
    check_eq("full.occ4", 32'(occupancy), 32'd4);
    expect_svc("full.c6", 16'h0011);
    put(4'd9, 16'h0016); step();
    check_eq("full.drop2", 32'(drop), 32'd0);
    check_eq("full.refill", 32'(full), 32'd1);
    check_eq("full.occ5b", 32'(occupancy), 32'd5);
    no_put();

    // Asynchronous reset mid-run
    do_reset(); start(2'd0);
    put(4'd9, 16'h0031); step();
    put(4'd9, 16'h0032); step();
    put(4'd9, 16'h0033); step();
    no_put();
    check_eq("mid.occ3", 32'(occupancy), 32'd3);
    #2 rst = 1'b0;
    #1;
    expect_svc("mid.rst", 16'hFFFF);
    check_eq("mid.empty", 32'(empty), 32'd1);
    check_eq("mid.occ0", 32'(occupancy), 32'd0);
    step(); step();
    rst = 1'b1;
    put(4'd5, 16'h0055); step(); step();
    expect_svc("mid.nost", 16'hFFFF);
    check_eq("mid.nost.occ", 32'(occupancy), 32'd0);
    no_put(); start(2'd0);

    // Zero-runtime insert is ignored without a drop
    put(4'd0, 16'h0077); step();
    check_eq("rt0.occ", 32'(occupancy), 32'd0);
    check_eq("rt0.drop", 32'(drop), 32'd0);
    expect_svc("rt0.out", 16'hFFFF);
    put(4'd2, 16'h0088); step();
    expect_svc("rt0.next", 16'h0088);
    check_eq("rt0.occ1", 32'(occupancy), 32'd1);
    no_put();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
